// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipelined control unit: opcode/funct encodings,
// ALU and HI/LO select encodings, the MDU sequencer state type, the E-stage
// control bundle and a helper that classifies unlisted instructions.
package pipe_ctrl_pkg;

    localparam int unsigned OP_W      = 6;
    localparam int unsigned FUNCT_W   = 6;
    localparam int unsigned ALU_ENC_W = 3;
    localparam int unsigned HILO_W    = 2;
    // Wide enough for MDU_LAT-1 with MDU_LAT up to 16
    localparam int unsigned MDU_CNT_W = 4;

    // Opcodes
    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;
    localparam logic [OP_W-1:0] OP_SLTI  = 6'b001010;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;

    // R-type funct codes
    localparam logic [FUNCT_W-1:0] FN_ADD  = 6'b100000;
    localparam logic [FUNCT_W-1:0] FN_SUB  = 6'b100010;
    localparam logic [FUNCT_W-1:0] FN_AND  = 6'b100100;
    localparam logic [FUNCT_W-1:0] FN_OR   = 6'b100101;
    localparam logic [FUNCT_W-1:0] FN_SLT  = 6'b101010;
    localparam logic [FUNCT_W-1:0] FN_JR   = 6'b001000;
    localparam logic [FUNCT_W-1:0] FN_MULT = 6'b011000;
    localparam logic [FUNCT_W-1:0] FN_DIV  = 6'b011010;
    localparam logic [FUNCT_W-1:0] FN_MFHI = 6'b010000;
    localparam logic [FUNCT_W-1:0] FN_MFLO = 6'b010010;

    // ALU operation encodings
    localparam logic [ALU_ENC_W-1:0] ALU_AND = 3'b000;
    localparam logic [ALU_ENC_W-1:0] ALU_OR  = 3'b001;
    localparam logic [ALU_ENC_W-1:0] ALU_ADD = 3'b010;
    localparam logic [ALU_ENC_W-1:0] ALU_SUB = 3'b110;
    localparam logic [ALU_ENC_W-1:0] ALU_SLT = 3'b111;

    // HI/LO read select
    localparam logic [HILO_W-1:0] HILO_NONE = 2'b00;
    localparam logic [HILO_W-1:0] HILO_HI   = 2'b01;
    localparam logic [HILO_W-1:0] HILO_LO   = 2'b10;

    typedef enum logic {
        MDU_IDLE = 1'b0,
        MDU_BUSY = 1'b1
    } mdu_state_t;

    // Control bundle carried from Decode into the E register
    typedef struct packed {
        logic                  aluSrc;
        logic                  regDst;
        logic                  regWrite;
        logic                  memToReg;
        logic                  memWrite;
        logic [ALU_ENC_W-1:0]  aluCtl;
        logic                  isMdu;     // mult or div
        logic                  mduDiv;    // 1 = div, 0 = mult
        logic [HILO_W-1:0]     hiloSel;
    } ctrl_e_t;

    // True for any opcode or R-type funct outside the supported set
    function automatic logic isIllegal(input logic [OP_W-1:0] op,
                                       input logic [FUNCT_W-1:0] funct);
        logic ill;
        ill = 1'b0;
        case (op)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT,
                    FN_JR, FN_MULT, FN_DIV, FN_MFHI, FN_MFLO: ill = 1'b0;
                    default:                                   ill = 1'b1;
                endcase
            end
            OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI,
            OP_ORI, OP_SLTI, OP_J:                             ill = 1'b0;
            default:                                           ill = 1'b1;
        endcase
        return ill;
    endfunction

endpackage

// File: rtl/pipe_ctrl_dec.sv
// Combinational Decode-stage control decoder.
// Ports:
//   opD, functD           : instruction opcode and funct in Decode
//   ctrlD                 : control bundle destined for the E register
//   branchD, bneD, jumpD,
//   jrD                   : control-flow flags consumed in Decode
// Unlisted opcodes/functs decode to an all-zero bundle (NOP).
module pipe_ctrl_dec
    import pipe_ctrl_pkg::*;
(
    input  logic [OP_W-1:0]    opD,
    input  logic [FUNCT_W-1:0] functD,
    output ctrl_e_t            ctrlD,
    output logic               branchD,
    output logic               bneD,
    output logic               jumpD,
    output logic               jrD
);

    // Main and ALU decode merged; every field defaults to zero first
    always_comb begin
        ctrlD   = '0;
        branchD = 1'b0;
        bneD    = 1'b0;
        jumpD   = 1'b0;
        jrD     = 1'b0;
        case (opD)
            OP_RTYPE: begin
                case (functD)
                    FN_ADD: begin
                        ctrlD.regWrite = 1'b1;
                        ctrlD.regDst   = 1'b1;
                        ctrlD.aluCtl   = ALU_ADD;
                    end
                    FN_SUB: begin
                        ctrlD.regWrite = 1'b1;
                        ctrlD.regDst   = 1'b1;
                        ctrlD.aluCtl   = ALU_SUB;
                    end
                    FN_AND: begin
                        ctrlD.regWrite = 1'b1;
                        ctrlD.regDst   = 1'b1;
                        ctrlD.aluCtl   = ALU_AND;
                    end
                    FN_OR: begin
                        ctrlD.regWrite = 1'b1;
                        ctrlD.regDst   = 1'b1;
                        ctrlD.aluCtl   = ALU_OR;
                    end
                    FN_SLT: begin
                        ctrlD.regWrite = 1'b1;
                        ctrlD.regDst   = 1'b1;
                        ctrlD.aluCtl   = ALU_SLT;
                    end
                    FN_JR: begin
                        jrD = 1'b1;
                    end
                    FN_MULT: begin
                        ctrlD.isMdu = 1'b1;
                    end
                    FN_DIV: begin
                        ctrlD.isMdu  = 1'b1;
                        ctrlD.mduDiv = 1'b1;
                    end
                    FN_MFHI: begin
                        ctrlD.regWrite = 1'b1;
                        ctrlD.regDst   = 1'b1;
                        ctrlD.hiloSel  = HILO_HI;
                    end
                    FN_MFLO: begin
                        ctrlD.regWrite = 1'b1;
                        ctrlD.regDst   = 1'b1;
                        ctrlD.hiloSel  = HILO_LO;
                    end
                    default: ;
                endcase
            end
            OP_LW: begin
                ctrlD.regWrite = 1'b1;
                ctrlD.aluSrc   = 1'b1;
                ctrlD.memToReg = 1'b1;
                ctrlD.aluCtl   = ALU_ADD;
            end
            OP_SW: begin
                ctrlD.aluSrc   = 1'b1;
                ctrlD.memWrite = 1'b1;
                ctrlD.aluCtl   = ALU_ADD;
            end
            OP_BEQ: begin
                branchD      = 1'b1;
                ctrlD.aluCtl = ALU_SUB;
            end
            OP_BNE: begin
                bneD         = 1'b1;
                ctrlD.aluCtl = ALU_SUB;
            end
            OP_ADDI: begin
                ctrlD.regWrite = 1'b1;
                ctrlD.aluSrc   = 1'b1;
                ctrlD.aluCtl   = ALU_ADD;
            end
            OP_ORI: begin
                ctrlD.regWrite = 1'b1;
                ctrlD.aluSrc   = 1'b1;
                ctrlD.aluCtl   = ALU_OR;
            end
            OP_SLTI: begin
                ctrlD.regWrite = 1'b1;
                ctrlD.aluSrc   = 1'b1;
                ctrlD.aluCtl   = ALU_SLT;
            end
            OP_J: begin
                jumpD = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/pipe_controller.sv
// Pipelined control unit: Decode-stage decode, E/M/W control registers with
// per-register stall/flush, and a multiply/divide sequencer that stalls
// Decode while a HI/LO result is pending.
// Parameters: ALUCTL_W (alucontrolE width), MDU_LAT (busy cycles, 1..16).
// Ports:
//   clk, reset (async, active-low)
//   opD, functD, equalD         : Decode inputs
//   stallE, flushE, flushM      : hazard-unit controls
//   pcsrcD, branchD, bneD,
//   jumpD, jrD, mdu_stallD      : Decode outputs (combinational)
//   *E / *M / *W                : registered stage controls
//   mdu_startE, mdu_opE,
//   mdu_busy                    : MDU sequencer interface
// Build option CTRL_ILLEGAL_EN adds illegalD (combinational) and the sticky
// illegal_seen register.
module pipe_controller
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned ALUCTL_W = 3,
    parameter int unsigned MDU_LAT  = 4
)
(
    input  logic                clk,
    input  logic                reset,
    input  logic [OP_W-1:0]     opD,
    input  logic [FUNCT_W-1:0]  functD,
    input  logic                equalD,
    input  logic                stallE,
    input  logic                flushE,
    input  logic                flushM,
    output logic                pcsrcD,
    output logic                branchD,
    output logic                bneD,
    output logic                jumpD,
    output logic                jrD,
    output logic                mdu_stallD,
    output logic                alusrcE,
    output logic                regdstE,
    output logic                regwriteE,
    output logic                memtoregE,
    output logic [ALUCTL_W-1:0] alucontrolE,
    output logic                mdu_startE,
    output logic                mdu_opE,
    output logic                mdu_busy,
    output logic [HILO_W-1:0]   hiloselE,
    output logic                memwriteM,
    output logic                memtoregM,
    output logic                regwriteM,
    output logic                memtoregW,
    output logic                regwriteW
`ifdef CTRL_ILLEGAL_EN
    ,
    output logic                illegalD,
    output logic                illegal_seen
`endif
);

    ctrl_e_t                ctrlD;
    ctrl_e_t                ctrlE;
    mdu_state_t             mduState;
    logic [MDU_CNT_W-1:0]   mduCnt;
    logic                   mduRelD;

    pipe_ctrl_dec uDec (
        .opD     (opD),
        .functD  (functD),
        .ctrlD   (ctrlD),
        .branchD (branchD),
        .bneD    (bneD),
        .jumpD   (jumpD),
        .jrD     (jrD)
    );

    assign pcsrcD = (branchD & equalD) | (bneD & ~equalD);

    // E register: flush beats stall
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrlE <= '0;
        end else if (flushE) begin
            ctrlE <= '0;
        end else if (!stallE) begin
            ctrlE <= ctrlD;
        end
    end

    // M register: a held E stage must not be duplicated into M, so insert a bubble
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            memwriteM <= 1'b0;
            memtoregM <= 1'b0;
            regwriteM <= 1'b0;
        end else if (flushM || stallE) begin
            memwriteM <= 1'b0;
            memtoregM <= 1'b0;
            regwriteM <= 1'b0;
        end else begin
            memwriteM <= ctrlE.memWrite;
            memtoregM <= ctrlE.memToReg;
            regwriteM <= ctrlE.regWrite;
        end
    end

    // W register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            memtoregW <= 1'b0;
            regwriteW <= 1'b0;
        end else begin
            memtoregW <= memtoregM;
            regwriteW <= regwriteM;
        end
    end

    assign alusrcE     = ctrlE.aluSrc;
    assign regdstE     = ctrlE.regDst;
    assign regwriteE   = ctrlE.regWrite;
    assign memtoregE   = ctrlE.memToReg;
    assign alucontrolE = ALUCTL_W'(ctrlE.aluCtl);
    assign hiloselE    = ctrlE.hiloSel;
    assign mdu_opE     = ctrlE.mduDiv;

    // Start only when the op actually leaves E this cycle and the unit is free;
    // an op arriving in E while BUSY is ignored rather than restarting
    assign mdu_startE = ctrlE.isMdu & (mduState == MDU_IDLE) & ~stallE & ~flushE;
    assign mdu_busy   = (mduState == MDU_BUSY);

    // MDU sequencer: MDU_LAT busy cycles, counting MDU_LAT-1 down to 0
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mduState <= MDU_IDLE;
            mduCnt   <= '0;
        end else begin
            case (mduState)
                MDU_IDLE: begin
                    if (mdu_startE) begin
                        mduState <= MDU_BUSY;
                        mduCnt   <= MDU_CNT_W'(MDU_LAT - 1);
                    end
                end
                MDU_BUSY: begin
                    if (mduCnt == '0) begin
                        mduState <= MDU_IDLE;
                    end else begin
                        mduCnt <= mduCnt - MDU_CNT_W'(1);
                    end
                end
                default: begin
                    mduState <= MDU_IDLE;
                    mduCnt   <= '0;
                end
            endcase
        end
    end

    // Any instruction touching the MDU or HI/LO waits for a pending result
    assign mduRelD    = ctrlD.isMdu | (ctrlD.hiloSel != HILO_NONE);
    assign mdu_stallD = mduRelD & (mdu_busy | ctrlE.isMdu);

`ifdef CTRL_ILLEGAL_EN
    assign illegalD = isIllegal(opD, functD);

    // Sticky flag; a flushed (squashed) Decode slot does not count
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            illegal_seen <= 1'b0;
        end else if (illegalD && !flushE) begin
            illegal_seen <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_controller.sv
// Directed testbench for pipe_controller: one default instance (MDU_LAT=4)
// and one MDU_LAT=1 instance sharing the same stimulus.
module tb_pipe_controller;

    logic       clk;
    logic       reset;
    logic [5:0] opD;
    logic [5:0] functD;
    logic       equalD;
    logic       stallE;
    logic       flushE;
    logic       flushM;

    logic       pcsrcD, branchD, bneD, jumpD, jrD, mdu_stallD;
    logic       alusrcE, regdstE, regwriteE, memtoregE;
    logic [2:0] alucontrolE;
    logic       mdu_startE, mdu_opE, mdu_busy;
    logic [1:0] hiloselE;
    logic       memwriteM, memtoregM, regwriteM, memtoregW, regwriteW;

    logic       pcsrcD1, branchD1, bneD1, jumpD1, jrD1, mdu_stallD1;
    logic       alusrcE1, regdstE1, regwriteE1, memtoregE1;
    logic [2:0] alucontrolE1;
    logic       mdu_startE1, mdu_opE1, mdu_busy1;
    logic [1:0] hiloselE1;
    logic       memwriteM1, memtoregM1, regwriteM1, memtoregW1, regwriteW1;
`ifdef CTRL_ILLEGAL_EN
    logic       illegalD, illegal_seen, illegalD1, illegal_seen1;
`endif

    int checks = 0;
    int fails  = 0;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_JR   = 6'b001000;
    localparam logic [5:0] FN_MULT = 6'b011000;
    localparam logic [5:0] FN_DIV  = 6'b011010;
    localparam logic [5:0] FN_MFLO = 6'b010010;

    pipe_controller dut (
        .clk(clk), .reset(reset), .opD(opD), .functD(functD), .equalD(equalD),
        .stallE(stallE), .flushE(flushE), .flushM(flushM),
        .pcsrcD(pcsrcD), .branchD(branchD), .bneD(bneD), .jumpD(jumpD), .jrD(jrD),
        .mdu_stallD(mdu_stallD), .alusrcE(alusrcE), .regdstE(regdstE),
        .regwriteE(regwriteE), .memtoregE(memtoregE), .alucontrolE(alucontrolE),
        .mdu_startE(mdu_startE), .mdu_opE(mdu_opE), .mdu_busy(mdu_busy),
        .hiloselE(hiloselE), .memwriteM(memwriteM), .memtoregM(memtoregM),
        .regwriteM(regwriteM), .memtoregW(memtoregW), .regwriteW(regwriteW)
`ifdef CTRL_ILLEGAL_EN
        , .illegalD(illegalD), .illegal_seen(illegal_seen)
`endif
    );

    pipe_controller #(.ALUCTL_W(3), .MDU_LAT(1)) dut1 (
        .clk(clk), .reset(reset), .opD(opD), .functD(functD), .equalD(equalD),
        .stallE(stallE), .flushE(flushE), .flushM(flushM),
        .pcsrcD(pcsrcD1), .branchD(branchD1), .bneD(bneD1), .jumpD(jumpD1), .jrD(jrD1),
        .mdu_stallD(mdu_stallD1), .alusrcE(alusrcE1), .regdstE(regdstE1),
        .regwriteE(regwriteE1), .memtoregE(memtoregE1), .alucontrolE(alucontrolE1),
        .mdu_startE(mdu_startE1), .mdu_opE(mdu_opE1), .mdu_busy(mdu_busy1),
        .hiloselE(hiloselE1), .memwriteM(memwriteM1), .memtoregM(memtoregM1),
        .regwriteM(regwriteM1), .memtoregW(memtoregW1), .regwriteW(regwriteW1)
`ifdef CTRL_ILLEGAL_EN
        , .illegalD(illegalD1), .illegal_seen(illegal_seen1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Sample point: 1 time unit after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setD(input logic [5:0] op, input logic [5:0] fn);
        opD    = op;
        functD = fn;
    endtask

    task automatic test_reset();
        logic [12:0] regs;
        setD(OP_R, FN_ADD);
        reset = 1'b0;
        tick(); tick();
        regs = {alusrcE, regdstE, regwriteE, memtoregE, alucontrolE, mdu_busy,
                hiloselE, memwriteM, regwriteM, regwriteW};
        checks++;
        if (regs !== 13'd0) begin
            fails++; $display("FAIL reset_state: got %b expected 0", regs);
        end
        reset = 1'b1;
        tick(); tick(); tick();
        checks++;
        if (regwriteW !== 1'b1) begin
            fails++; $display("FAIL pre_reset_regwriteW: got %b expected 1", regwriteW);
        end
        // Assert reset between edges; registers must clear without a clock edge
        #2 reset = 1'b0;
        #1;
        regs = {alusrcE, regdstE, regwriteE, memtoregE, alucontrolE, mdu_busy,
                hiloselE, memwriteM, regwriteM, regwriteW};
        checks++;
        if (regs !== 13'd0) begin
            fails++; $display("FAIL async_reset: got %b expected 0", regs);
        end
        tick();
        reset = 1'b1;
        tick();
        checks++;
        if ({regwriteE, alucontrolE} !== 4'b1010) begin
            fails++; $display("FAIL add_E: got %b expected 1010", {regwriteE, alucontrolE});
        end
        checks++;
        if (regwriteW !== 1'b0) begin
            fails++; $display("FAIL add_W_early: got %b expected 0", regwriteW);
        end
        tick();
        checks++;
        if (regwriteM !== 1'b1) begin
            fails++; $display("FAIL add_M: got %b expected 1", regwriteM);
        end
        tick();
        checks++;
        if (regwriteW !== 1'b1) begin
            fails++; $display("FAIL add_W: got %b expected 1", regwriteW);
        end
    endtask

    task automatic test_branch_jr();
        setD(OP_BEQ, 6'd0); equalD = 1'b1; #1;
        checks++;
        if ({branchD, pcsrcD} !== 2'b11) begin
            fails++; $display("FAIL beq_taken: got %b expected 11", {branchD, pcsrcD});
        end
        setD(OP_BNE, 6'd0); equalD = 1'b1; #1;
        checks++;
        if ({bneD, pcsrcD} !== 2'b10) begin
            fails++; $display("FAIL bne_eq: got %b expected 10", {bneD, pcsrcD});
        end
        equalD = 1'b0; #1;
        checks++;
        if ({bneD, pcsrcD} !== 2'b11) begin
            fails++; $display("FAIL bne_ne: got %b expected 11", {bneD, pcsrcD});
        end
        setD(OP_J, 6'd0); #1;
        checks++;
        if ({jumpD, branchD, bneD, jrD} !== 4'b1000) begin
            fails++; $display("FAIL j_flags: got %b expected 1000", {jumpD, branchD, bneD, jrD});
        end
        setD(OP_R, FN_JR); #1;
        checks++;
        if ({jrD, jumpD, pcsrcD} !== 3'b100) begin
            fails++; $display("FAIL jr_flags: got %b expected 100", {jrD, jumpD, pcsrcD});
        end
        tick();
        setD(OP_BEQ, 6'd0);
        checks++;
        if (regwriteE !== 1'b0) begin
            fails++; $display("FAIL jr_regwriteE: got %b expected 0", regwriteE);
        end
        tick();
        checks++;
        if (regwriteM !== 1'b0) begin
            fails++; $display("FAIL jr_regwriteM: got %b expected 0", regwriteM);
        end
        tick();
        checks++;
        if (regwriteW !== 1'b0) begin
            fails++; $display("FAIL jr_regwriteW: got %b expected 0", regwriteW);
        end
    endtask

    task automatic test_mdu();
        int busyN;
        int startN;
        equalD = 1'b0;
        setD(OP_R, FN_MULT); #1;
        checks++;
        if (mdu_stallD !== 1'b0) begin
            fails++; $display("FAIL mult_D_nostall: got %b expected 0", mdu_stallD);
        end
        tick();
        setD(OP_BEQ, 6'd0); #1;
        checks++;
        if ({mdu_startE, mdu_opE, mdu_busy} !== 3'b100) begin
            fails++; $display("FAIL mult_start: got %b expected 100", {mdu_startE, mdu_opE, mdu_busy});
        end
        startN = mdu_startE ? 1 : 0;
        tick();
        // mflo waits in Decode; the hazard unit bubbles E meanwhile
        setD(OP_R, FN_MFLO); flushE = 1'b1; #1;
        busyN = 0;
        for (int i = 0; i < 20; i++) begin
            if (!mdu_busy) break;
            busyN++;
            startN += mdu_startE ? 1 : 0;
            checks++;
            if (mdu_stallD !== 1'b1) begin
                fails++; $display("FAIL mflo_stall: got %b expected 1 at busy cycle %0d", mdu_stallD, busyN);
            end
            tick();
        end
        checks++;
        if (busyN != 4) begin
            fails++; $display("FAIL mdu_busy_len: got %0d expected 4", busyN);
        end
        checks++;
        if (startN != 1) begin
            fails++; $display("FAIL mdu_start_count: got %0d expected 1", startN);
        end
        checks++;
        if (mdu_stallD !== 1'b0) begin
            fails++; $display("FAIL mflo_release: got %b expected 0", mdu_stallD);
        end
        flushE = 1'b0;
        tick();
        setD(OP_BEQ, 6'd0);
        checks++;
        if ({hiloselE, regwriteE, regdstE} !== 4'b1011) begin
            fails++; $display("FAIL mflo_E: got %b expected 1011", {hiloselE, regwriteE, regdstE});
        end
    endtask

    task automatic test_flush_stall();
        setD(OP_LW, 6'd0);
        tick();
        checks++;
        if ({memtoregE, alusrcE, regwriteE} !== 3'b111) begin
            fails++; $display("FAIL lw_E: got %b expected 111", {memtoregE, alusrcE, regwriteE});
        end
        flushE = 1'b1; stallE = 1'b1;
        tick();
        checks++;
        if ({memtoregE, alusrcE, regwriteE} !== 3'b000) begin
            fails++; $display("FAIL flush_over_stall: got %b expected 000", {memtoregE, alusrcE, regwriteE});
        end
        checks++;
        if (memtoregM !== 1'b0) begin
            fails++; $display("FAIL flush_stall_M: got %b expected 0", memtoregM);
        end
        flushE = 1'b0; stallE = 1'b0;
        setD(OP_SW, 6'd0);
        tick();
        stallE = 1'b1;
        setD(OP_R, FN_ADD);
        tick();
        checks++;
        if ({alusrcE, regwriteE, alucontrolE} !== 5'b10010) begin
            fails++; $display("FAIL stall_hold_E: got %b expected 10010", {alusrcE, regwriteE, alucontrolE});
        end
        checks++;
        if (memwriteM !== 1'b0) begin
            fails++; $display("FAIL stall_bubble_M: got %b expected 0", memwriteM);
        end
        stallE = 1'b0;
        tick();
        checks++;
        if ({memwriteM, regwriteE, alusrcE} !== 3'b110) begin
            fails++; $display("FAIL after_stall: got %b expected 110", {memwriteM, regwriteE, alusrcE});
        end
        flushM = 1'b1;
        setD(OP_BEQ, 6'd0);
        tick();
        flushM = 1'b0;
        checks++;
        if ({regwriteM, memwriteM} !== 2'b00) begin
            fails++; $display("FAIL flushM: got %b expected 00", {regwriteM, memwriteM});
        end
    endtask

    task automatic test_illegal();
        equalD = 1'b1;
`ifdef CTRL_ILLEGAL_EN
        #1;
        checks++;
        if ({illegalD, illegal_seen} !== 2'b00) begin
            fails++; $display("FAIL illegal_clear: got %b expected 00", {illegalD, illegal_seen});
        end
`endif
        setD(6'b111111, 6'd0); #1;
        checks++;
        if ({pcsrcD, branchD, bneD, jumpD, jrD, mdu_stallD} !== 6'd0) begin
            fails++; $display("FAIL illegal_D: got %b expected 0", {pcsrcD, branchD, bneD, jumpD, jrD, mdu_stallD});
        end
`ifdef CTRL_ILLEGAL_EN
        checks++;
        if (illegalD !== 1'b1) begin
            fails++; $display("FAIL illegalD_op: got %b expected 1", illegalD);
        end
`endif
        tick();
        setD(OP_R, FN_ADD);
        checks++;
        if ({alusrcE, regdstE, regwriteE, memtoregE, alucontrolE, hiloselE} !== 9'd0) begin
            fails++; $display("FAIL illegal_E: got %b expected 0", {alusrcE, regdstE, regwriteE, memtoregE, alucontrolE, hiloselE});
        end
`ifdef CTRL_ILLEGAL_EN
        tick(); tick();
        checks++;
        if ({illegalD, illegal_seen} !== 2'b01) begin
            fails++; $display("FAIL illegal_sticky: got %b expected 01", {illegalD, illegal_seen});
        end
        setD(OP_R, 6'b111111); #1;
        checks++;
        if (illegalD !== 1'b1) begin
            fails++; $display("FAIL illegalD_funct: got %b expected 1", illegalD);
        end
        setD(OP_BEQ, 6'd0);
        reset = 1'b0; #1;
        checks++;
        if (illegal_seen !== 1'b0) begin
            fails++; $display("FAIL illegal_reset: got %b expected 0", illegal_seen);
        end
        tick();
        reset = 1'b1;
`endif
        setD(OP_BEQ, 6'd0);
        equalD = 1'b0;
        tick();
    endtask

    task automatic test_mdu_lat1();
        int busyN;
        setD(OP_R, FN_DIV);
        tick();
        setD(OP_BEQ, 6'd0); #1;
        checks++;
        if ({mdu_startE1, mdu_opE1} !== 2'b11) begin
            fails++; $display("FAIL div_start_lat1: got %b expected 11", {mdu_startE1, mdu_opE1});
        end
        busyN = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (mdu_busy1) busyN++;
            else break;
        end
        checks++;
        if (busyN != 1) begin
            fails++; $display("FAIL div_busy_lat1: got %0d expected 1", busyN);
        end
    endtask

    initial begin
        reset = 1'b0; opD = '0; functD = '0; equalD = 1'b0;
        stallE = 1'b0; flushE = 1'b0; flushM = 1'b0;
        test_reset();
        test_branch_jr();
        test_mdu();
        test_flush_stall();
        test_illegal();
        test_mdu_lat1();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
